// File: rtl/fibo_scroll_ctrl.sv
// fibo_scroll_ctrl: fills an on-chip RAM with Fibonacci terms after reset,
// then shows two adjacent entries as 16-char ASCII rows for the LCD and
// scrolls them one entry per step_tick in the current direction.
// Optional build macro: FIBO_CLAMP_EN (stop scrolling at table ends
// instead of wrapping around).
module fibo_scroll_ctrl #(
  parameter int NUM_TERMS = 25,
  parameter int DATA_W    = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step_tick,
  input  logic         dir_toggle,
  output logic [127:0] row_a,
  output logic [127:0] row_b,
  output logic         busy,
  output logic         dir,
  output logic [6:0]   top_idx,
  output logic         sat_any
);

  localparam int            AW       = $clog2(NUM_TERMS);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_TERMS - 1);
  localparam logic [7:0]    N_BCD    = {4'(NUM_TERMS / 10), 4'(NUM_TERMS % 10)};

  typedef enum logic [1:0] {S_FILL, S_SHOW, S_FETCH} state_t;

  function automatic logic [AW-1:0] idx_inc(input logic [AW-1:0] i);
    return (i == LAST_IDX) ? AW'(0) : i + AW'(1);
  endfunction

  function automatic logic [AW-1:0] idx_dec(input logic [AW-1:0] i);
    return (i == AW'(0)) ? LAST_IDX : i - AW'(1);
  endfunction

  // Two-digit BCD label (1-based) stepping with the same wrap as the index.
  function automatic logic [7:0] bcd_inc(input logic [7:0] b);
    if (b == N_BCD)             return 8'h01;
    else if (b[3:0] == 4'd9)    return {b[7:4] + 4'd1, 4'd0};
    else                        return {b[7:4], b[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] b);
    if (b == 8'h01)             return N_BCD;
    else if (b[3:0] == 4'd0)    return {b[7:4] - 4'd1, 4'd9};
    else                        return {b[7:4], b[3:0] - 4'd1};
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'd0, n} : 8'h37 + {4'd0, n};
  endfunction

  function automatic logic [127:0] fmt_row(input logic [7:0] bcd, input logic sat,
                                           input logic [15:0] val);
    logic [31:0] digits;
    if (sat) digits = "OVFL";
    else     digits = {hex_char(val[15:12]), hex_char(val[11:8]),
                       hex_char(val[7:4]), hex_char(val[3:0])};
    return {"Fibo #", 8'h30 + {4'd0, bcd[7:4]}, 8'h30 + {4'd0, bcd[3:0]}, " is ", digits};
  endfunction

  localparam logic [127:0] ROW_A_RST = fmt_row(8'h01, 1'b0, 16'd0);
  localparam logic [127:0] ROW_B_RST = fmt_row(8'h02, 1'b0, 16'd1);

  state_t              state_q, state_d;
  logic [AW-1:0]       ptr_q, ptr_d, top_q, top_d;
  logic [DATA_W-1:0]   fa_q, fa_d, fb_q, fb_d;
  logic                fa_sat_q, fa_sat_d, fb_sat_q, fb_sat_d;
  logic [127:0]        row_a_q, row_a_d, row_b_q, row_b_d;
  logic                busy_q, busy_d, dir_q, dir_d, sat_any_q, sat_any_d;
  logic                fetch_dir_q, fetch_dir_d;
  logic [7:0]          bcd_a_q, bcd_a_d, bcd_b_q, bcd_b_d;
  logic [DATA_W:0]     mem [NUM_TERMS];
  logic [DATA_W:0]     rd_q;
  logic [AW-1:0]       rd_addr_s;
  logic                we_s, clamp_s;
  logic [DATA_W:0]     sum_raw_s;
  logic                sum_sat_s;
  logic [DATA_W-1:0]   sum_val_s;

  // Saturating next Fibonacci term from the two running registers.
  always_comb begin
    sum_raw_s = {1'b0, fa_q} + {1'b0, fb_q};
    sum_sat_s = sum_raw_s[DATA_W] | fa_sat_q | fb_sat_q;
    sum_val_s = sum_sat_s ? {DATA_W{1'b1}} : sum_raw_s[DATA_W-1:0];
  end

`ifdef FIBO_CLAMP_EN
  assign clamp_s = dir_q ? (top_q == AW'(0)) : (top_q == LAST_IDX - AW'(1));
`else
  assign clamp_s = 1'b0;
`endif

  // Next-state and datapath for fill, show and fetch.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    top_d       = top_q;
    fa_d        = fa_q;
    fa_sat_d    = fa_sat_q;
    fb_d        = fb_q;
    fb_sat_d    = fb_sat_q;
    row_a_d     = row_a_q;
    row_b_d     = row_b_q;
    busy_d      = busy_q;
    sat_any_d   = sat_any_q;
    fetch_dir_d = fetch_dir_q;
    bcd_a_d     = bcd_a_q;
    bcd_b_d     = bcd_b_q;
    we_s        = 1'b0;
    rd_addr_s   = top_q;
    dir_d       = dir_q ^ dir_toggle;
    case (state_q)
      S_FILL: begin
        we_s     = 1'b1;
        fa_d     = fb_q;
        fa_sat_d = fb_sat_q;
        fb_d     = sum_val_s;
        fb_sat_d = sum_sat_s;
        if (fa_sat_q) sat_any_d = 1'b1;
        else          sat_any_d = sat_any_q;
        if (ptr_q == LAST_IDX) begin
          state_d = S_SHOW;
          busy_d  = 1'b0;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      S_SHOW: begin
        if (step_tick && !clamp_s) begin
          state_d     = S_FETCH;
          busy_d      = 1'b1;
          fetch_dir_d = dir_q;
          if (!dir_q) begin
            top_d     = idx_inc(top_q);
            rd_addr_s = idx_inc(idx_inc(top_q));
            bcd_a_d   = bcd_inc(bcd_a_q);
            bcd_b_d   = bcd_inc(bcd_b_q);
          end else begin
            top_d     = idx_dec(top_q);
            rd_addr_s = idx_dec(top_q);
            bcd_a_d   = bcd_dec(bcd_a_q);
            bcd_b_d   = bcd_dec(bcd_b_q);
          end
        end else begin
          state_d = S_SHOW;
        end
      end
      S_FETCH: begin
        state_d = S_SHOW;
        busy_d  = 1'b0;
        if (!fetch_dir_q) begin
          row_a_d = row_b_q;
          row_b_d = fmt_row(bcd_b_q, rd_q[DATA_W], 16'(rd_q[DATA_W-1:0]));
        end else begin
          row_b_d = row_a_q;
          row_a_d = fmt_row(bcd_a_q, rd_q[DATA_W], 16'(rd_q[DATA_W-1:0]));
        end
      end
      default: begin
        state_d = S_FILL;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FILL;
      ptr_q       <= AW'(0);
      top_q       <= AW'(0);
      fa_q        <= DATA_W'(0);
      fa_sat_q    <= 1'b0;
      fb_q        <= DATA_W'(1);
      fb_sat_q    <= 1'b0;
      row_a_q     <= ROW_A_RST;
      row_b_q     <= ROW_B_RST;
      busy_q      <= 1'b1;
      dir_q       <= 1'b0;
      sat_any_q   <= 1'b0;
      fetch_dir_q <= 1'b0;
      bcd_a_q     <= 8'h01;
      bcd_b_q     <= 8'h02;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      top_q       <= top_d;
      fa_q        <= fa_d;
      fa_sat_q    <= fa_sat_d;
      fb_q        <= fb_d;
      fb_sat_q    <= fb_sat_d;
      row_a_q     <= row_a_d;
      row_b_q     <= row_b_d;
      busy_q      <= busy_d;
      dir_q       <= dir_d;
      sat_any_q   <= sat_any_d;
      fetch_dir_q <= fetch_dir_d;
      bcd_a_q     <= bcd_a_d;
      bcd_b_q     <= bcd_b_d;
    end
  end

  // Table RAM: one write port for filling, one registered read port.
  always_ff @(posedge clk) begin
    if (we_s) mem[ptr_q] <= {fa_sat_q, fa_q};
    rd_q <= mem[rd_addr_s];
  end

  assign row_a   = row_a_q;
  assign row_b   = row_b_q;
  assign busy    = busy_q;
  assign dir     = dir_q;
  assign top_idx = 7'(top_q);
  assign sat_any = sat_any_q;

endmodule

// File: tb/tb_fibo_scroll_ctrl.sv
// Directed bench for fibo_scroll_ctrl: default 25-entry table plus a
// 30-entry instance sharing the same stimulus to exercise saturation.
module tb_fibo_scroll_ctrl;
  logic         clk = 1'b0;
  logic         reset, step_tick, dir_toggle;
  logic [127:0] row_a, row_b, row_a30, row_b30;
  logic         busy, dir, sat_any, busy30, dir30, sat_any30;
  logic [6:0]   top_idx, top_idx30;
  int           n_checks = 0;
  int           n_fails  = 0;
  int           cyc;

  always #5 clk = ~clk;

  fibo_scroll_ctrl dut (
    .clk(clk), .reset(reset), .step_tick(step_tick), .dir_toggle(dir_toggle),
    .row_a(row_a), .row_b(row_b), .busy(busy), .dir(dir),
    .top_idx(top_idx), .sat_any(sat_any)
  );

  fibo_scroll_ctrl #(.NUM_TERMS(30), .DATA_W(16)) dut30 (
    .clk(clk), .reset(reset), .step_tick(step_tick), .dir_toggle(dir_toggle),
    .row_a(row_a30), .row_b(row_b30), .busy(busy30), .dir(dir30),
    .top_idx(top_idx30), .sat_any(sat_any30)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step_pulse();
    step_tick = 1'b1;
    tick();
    step_tick = 1'b0;
    tick();
    tick();
  endtask

  task automatic count_fill(output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while (busy !== 1'b0 && c < 200);
  endtask

  initial begin
    reset = 1'b1; step_tick = 1'b0; dir_toggle = 1'b0;
    repeat (3) tick();
    chk("rst_row_a", row_a, "Fibo #01 is 0000");
    chk("rst_row_b", row_b, "Fibo #02 is 0001");
    chk("rst_busy", busy, 1'b1);
    chk("rst_dir", dir, 1'b0);
    chk("rst_top", top_idx, 7'd0);
    chk("rst_sat", sat_any, 1'b0);

    reset = 1'b0;
    count_fill(cyc);
    chk("fill_cycles", cyc, 25);
    chk("fill_row_a", row_a, "Fibo #01 is 0000");
    chk("fill_row_b", row_b, "Fibo #02 is 0001");
    chk("fill_sat", sat_any, 1'b0);
    repeat (6) tick();
    chk("fill30_busy", busy30, 1'b0);

    for (int i = 0; i < 23; i++) step_pulse();
    chk("s23_row_a", row_a, "Fibo #24 is 6FF1");
    chk("s23_row_b", row_b, "Fibo #25 is B520");
    chk("s23_top", top_idx, 7'd23);

    step_pulse();
    chk("s24_row_a", row_a, "Fibo #25 is B520");
    chk("s24_row_b", row_b, "Fibo #01 is 0000");
    chk("s24_top", top_idx, 7'd24);
    chk("s24_sat", sat_any, 1'b0);
    chk("n30_row_a", row_a30, "Fibo #25 is B520");
    chk("n30_row_b", row_b30, "Fibo #26 is OVFL");
    chk("n30_sat", sat_any30, 1'b1);

    // back-to-back ticks: second lands in FETCH and is dropped
    step_tick = 1'b1;
    tick();
    tick();
    step_tick = 1'b0;
    tick();
    tick();
    chk("b2b_top", top_idx, 7'd0);
    chk("b2b_row_a", row_a, "Fibo #01 is 0000");
    chk("b2b_row_b", row_b, "Fibo #02 is 0001");
    chk("b2b30_row_b", row_b30, "Fibo #27 is OVFL");

    // toggle and step together: step still goes down
    step_tick = 1'b1; dir_toggle = 1'b1;
    tick();
    step_tick = 1'b0; dir_toggle = 1'b0;
    tick();
    tick();
    chk("ts_dir", dir, 1'b1);
    chk("ts_top", top_idx, 7'd1);
    chk("ts_row_a", row_a, "Fibo #02 is 0001");
    chk("ts_row_b", row_b, "Fibo #03 is 0001");
    dir_toggle = 1'b1;
    tick();
    dir_toggle = 1'b0;
    chk("tog_dir", dir, 1'b0);

    // reset mid-fill restarts the table
    reset = 1'b1;
    tick();
    chk("rst2_top", top_idx, 7'd0);
    chk("rst2_row_b", row_b, "Fibo #02 is 0001");
    reset = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    count_fill(cyc);
    chk("refill_cycles", cyc, 25);

    // reverse step from the reset view
    dir_toggle = 1'b1;
    tick();
    dir_toggle = 1'b0;
    chk("rev_dir", dir, 1'b1);
    step_tick = 1'b1;
    tick();
    step_tick = 1'b0;
`ifdef FIBO_CLAMP_EN
    chk("clamp_busy", busy, 1'b0);
    chk("clamp_top", top_idx, 7'd0);
    tick();
    chk("clamp_row_a", row_a, "Fibo #01 is 0000");
    chk("clamp_row_b", row_b, "Fibo #02 is 0001");
`else
    chk("rev_busy1", busy, 1'b1);
    chk("rev_top", top_idx, 7'd24);
    chk("rev_row_a_early", row_a, "Fibo #01 is 0000");
    tick();
    chk("rev_busy2", busy, 1'b0);
    chk("rev_row_a", row_a, "Fibo #25 is B520");
    chk("rev_row_b", row_b, "Fibo #01 is 0000");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule

// File: doc/fibo_scroll_ctrl.md
Name: fibo_scroll_ctrl

Overview:
Parametrised Fibonacci table generator and two-row scroll controller for the 16x2 LCD path.
- After reset it fills an internal synchronous RAM with NUM_TERMS Fibonacci values, one per cycle.
- It then presents two adjacent entries as 16-char ASCII rows for LCD_module.
- Scrolling is driven by an external step tick and a direction-toggle pulse.
- Adds saturation detection, 2-digit decimal index, configurable depth/width, and clean handling of steps during fetch.

Parameters:
NUM_TERMS, 25, table depth (entries #01..#NUM_TERMS), legal 3..99
DATA_W, 16, stored value width in bits, legal 4..16

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
step_tick  in  1  one-cycle pulse: scroll one entry in current direction
dir_toggle  in  1  one-cycle pulse, already debounced/edge-detected: invert direction
row_a  out  128  top LCD row, ASCII, char 0 in [127:120]
row_b  out  128  bottom LCD row, same format
busy  out  1  high while filling or fetching
dir  out  1  0 = down (indices increase), 1 = up
top_idx  out  7  0-based table index shown on row_a
sat_any  out  1  sticky: at least one entry saturated

Behaviour:
- Reset values:
  - row_a = "Fibo #01 is 0000", row_b = "Fibo #02 is 0001".
  - busy=1, dir=0, top_idx=0, sat_any=0, FSM=FILL, fill pointer=0.
- Entry k (0-based) holds F(k): F(0)=0, F(1)=1, F(k)=F(k-1)+F(k-2).
  - RAM word = {sat, value[DATA_W-1:0]}.
- Saturation: if the DATA_W+1-bit sum exceeds 2^DATA_W-1, or either operand is saturated:
  - store value all-ones with sat=1;
  - set sat_any=1, which stays set until reset.
- FILL: one RAM write per cycle; two running registers hold the previous two terms (no RAM read-back).
  - Pointer reaches NUM_TERMS-1 → next state SHOW, busy=0.
  - busy falls exactly NUM_TERMS cycles after reset deasserts.
- SHOW: row_a shows index top_idx, row_b shows (top_idx+1) mod NUM_TERMS.
- step_tick in SHOW, dir=0:
  - top_idx <= (top_idx+1) mod N;
  - read index (old top_idx+2) mod N;
  - go FETCH, busy=1.
- step_tick in SHOW, dir=1:
  - top_idx <= (top_idx-1) mod N;
  - read index new top_idx;
  - go FETCH.
- FETCH, 1 cycle (RAM read latency):
  - dir=0: row_a <= row_b, row_b <= formatted word.
  - dir=1: row_b <= row_a, row_a <= formatted word.
  - Return to SHOW, busy=0.
  - Rows change exactly 2 cycles after the step_tick cycle.
- step_tick while FILL or FETCH: ignored, not queued.
- dir_toggle: accepted in any state except during reset; dir flips next cycle.
  - Same-cycle dir_toggle and step_tick: the step uses the old direction.
  - A toggle during FETCH does not affect the fetch in flight.
- Row format, 16 chars:
  - "Fibo #" + index+1 as 2 decimal digits (leading '0') + " is " + 4 digit chars.
  - Digits: uppercase hex of value zero-extended to 16 bits.
  - If sat=1, the digit field is "OVFL".
  - Decimal index is kept in BCD counters stepped alongside top_idx (no divider).
- Wrap-around: index N-1 down → 0; index 0 up → N-1. BCD counters wrap identically.
- Reset mid-FILL or mid-FETCH: full restart; the table is refilled.

Optional Feature:
FIBO_CLAMP_EN
- Defined: scrolling stops at the table ends.
  - step_tick with dir=0 and top_idx=N-2, or dir=1 and top_idx=0: ignored, no FETCH, rows unchanged, busy stays 0.
- Undefined: circular wrap as described in Behaviour.

Test Plan:
- Default params; release reset, count cycles → busy falls after 25 cycles; rows still "Fibo #01 is 0000"/"Fibo #02 is 0001".
- 23 down step_ticks, spaced ≥3 cycles → row_a "Fibo #24 is 6FF1", row_b "Fibo #25 is B520", top_idx=23. One more step → row_a "Fibo #25 is B520", row_b "Fibo #01 is 0000".
- From reset state: dir_toggle, then step_tick → row_a "Fibo #25 is B520", row_b "Fibo #01 is 0000", top_idx=24; row change exactly 2 cycles after the tick.
- NUM_TERMS=30: scroll so row_b shows #26 → "Fibo #26 is OVFL", sat_any=1. #25 still "B520".
- step_tick on consecutive cycles → only the first is accepted; top_idx changes by 1. Same-cycle toggle+step → step in old direction, dir flips.
- FIBO_CLAMP_EN defined: from reset state, dir=1 step → no change, busy stays 0. Reset asserted mid-FILL (cycle 10) → fill restarts, busy falls 25 cycles after release.
